// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - Two-write-port byte-lane register file with write-through reads and busy scoreboard
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   ra1/ra2           read addresses; rd1/rd2 read data (same-cycle write bypass)
//   rbusy1/rbusy2     scoreboard busy of ra1/ra2, bypassed like data
//   wea/waa/wda/bea   write port A: enable, address, data, byte-lane enables
//   web/wab/wdb/beb   write port B (wins over A per lane)
//   iss_en/iss_addr   issue strobe marking a destination register busy
//   busy_vec          registered scoreboard, bit i = register i busy
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     ra1,
  input  logic [ADDR_W-1:0]     ra2,
  output logic [DATA_W-1:0]     rd1,
  output logic [DATA_W-1:0]     rd2,
  output logic                  rbusy1,
  output logic                  rbusy2,
  input  logic                  wea,
  input  logic                  web,
  input  logic [ADDR_W-1:0]     waa,
  input  logic [ADDR_W-1:0]     wab,
  input  logic [DATA_W-1:0]     wda,
  input  logic [DATA_W-1:0]     wdb,
  input  logic [DATA_W/8-1:0]   bea,
  input  logic [DATA_W/8-1:0]   beb,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic [2**ADDR_W-1:0]  busy_vec
);

  localparam int NREG = 2**ADDR_W;
  localparam int NB   = DATA_W/8;

  logic [DATA_W-1:0] regs [NREG] = '{default: '0};
  logic [NREG-1:0]   busy = '0;

  assign busy_vec = busy;

  // Register r as it will look after this edge: each lane takes B if B
  // writes it, else A if A writes it, else keeps its stored byte.
  function automatic logic [DATA_W-1:0] merged(input logic [DATA_W-1:0] cur,
                                               input logic [ADDR_W-1:0] r);
    logic [DATA_W-1:0] v;
    v = cur;
    for (int k = 0; k < NB; k++) begin
      if (web && (wab == r) && beb[k])
        v[8*k +: 8] = wdb[8*k +: 8];
      else if (wea && (waa == r) && bea[k])
        v[8*k +: 8] = wda[8*k +: 8];
    end
    return v;
  endfunction

  // A real write (at least one lane) retires the producer, unless a new
  // producer for the same register is issued in the same cycle.
  function automatic logic clears(input logic [ADDR_W-1:0] r);
    logic wr_hit;
    wr_hit = (wea && (waa == r) && (|bea)) || (web && (wab == r) && (|beb));
    return wr_hit && !(iss_en && (iss_addr == r));
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] r);
    return (ZERO_REG != 0) && (r == '0);
  endfunction

  always_comb begin
    rd1    = is_zero(ra1) ? '0 : merged(regs[ra1], ra1);
    rd2    = is_zero(ra2) ? '0 : merged(regs[ra2], ra2);
    rbusy1 = !is_zero(ra1) && busy[ra1] && !clears(ra1);
    rbusy2 = !is_zero(ra2) && busy[ra2] && !clears(ra2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
      busy <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (!is_zero(ADDR_W'(i))) begin
          regs[i] <= merged(regs[i], ADDR_W'(i));
          if (iss_en && (iss_addr == ADDR_W'(i)))
            busy[i] <= 1'b1;
          else if (clears(ADDR_W'(i)))
            busy[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - Self-checking bench for regfile_sb (ZERO_REG=1/0 at 32x32, plus 64-bit x 8 config)
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [4:0]  ra1, ra2, waa, wab, iss_addr;
  logic        wea, web, iss_en;
  logic [31:0] wda, wdb;
  logic [3:0]  bea, beb;

  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b, busy_a, busy_b;
  logic        rbusy1_a, rbusy2_a, rbusy1_b, rbusy2_b;

  logic [2:0]  c_ra1, c_ra2, c_waa, c_wab, c_iss_addr;
  logic        c_wea, c_web, c_iss_en, c_rbusy1, c_rbusy2;
  logic [63:0] c_wda, c_wdb, c_rd1, c_rd2;
  logic [7:0]  c_bea, c_beb, c_busy;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_a (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
    .rbusy1(rbusy1_a), .rbusy2(rbusy2_a), .wea(wea), .web(web), .waa(waa), .wab(wab),
    .wda(wda), .wdb(wdb), .bea(bea), .beb(beb), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_vec(busy_a));

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_b (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .rbusy1(rbusy1_b), .rbusy2(rbusy2_b), .wea(wea), .web(web), .waa(waa), .wab(wab),
    .wda(wda), .wdb(wdb), .bea(bea), .beb(beb), .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_vec(busy_b));

  regfile_sb #(.DATA_W(64), .ADDR_W(3)) u_c (
    .clk(clk), .reset(reset), .ra1(c_ra1), .ra2(c_ra2), .rd1(c_rd1), .rd2(c_rd2),
    .rbusy1(c_rbusy1), .rbusy2(c_rbusy2), .wea(c_wea), .web(c_web), .waa(c_waa),
    .wab(c_wab), .wda(c_wda), .wdb(c_wdb), .bea(c_bea), .beb(c_beb), .iss_en(c_iss_en),
    .iss_addr(c_iss_addr), .busy_vec(c_busy));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: byte storage per instance (0 = zero-reg instance, 1 = plain),
  // plus a busy flag per register.
  bit [7:0] mem   [2][32][4];
  bit       mbusy [2][32];

  function automatic logic [31:0] m_rd(input int inst, input logic [4:0] a);
    logic [7:0] b [4];
    if (inst == 0 && a == 0) return 32'h0;
    for (int k = 0; k < 4; k++) b[k] = mem[inst][a][k];
    if (wea && waa == a) for (int k = 0; k < 4; k++) if (bea[k]) b[k] = wda[8*k +: 8];
    if (web && wab == a) for (int k = 0; k < 4; k++) if (beb[k]) b[k] = wdb[8*k +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  function automatic logic m_rbusy(input int inst, input logic [4:0] a);
    logic written, reissued;
    if (inst == 0 && a == 0) return 1'b0;
    written  = (wea && waa == a && bea != 0) || (web && wab == a && beb != 0);
    reissued = iss_en && iss_addr == a;
    return mbusy[inst][a] && !(written && !reissued);
  endfunction

  function automatic logic [31:0] m_busy(input int inst);
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = mbusy[inst][r];
    return v;
  endfunction

  always @(posedge clk) begin
    for (int inst = 0; inst < 2; inst++) begin
      if (reset) begin
        for (int r = 0; r < 32; r++) begin
          mbusy[inst][r] = 1'b0;
          for (int k = 0; k < 4; k++) mem[inst][r][k] = 8'h0;
        end
      end else begin
        if (wea && bea != 0 && !(inst == 0 && waa == 0)) begin
          for (int k = 0; k < 4; k++) if (bea[k]) mem[inst][waa][k] = wda[8*k +: 8];
          mbusy[inst][waa] = 1'b0;
        end
        if (web && beb != 0 && !(inst == 0 && wab == 0)) begin
          for (int k = 0; k < 4; k++) if (beb[k]) mem[inst][wab][k] = wdb[8*k +: 8];
          mbusy[inst][wab] = 1'b0;
        end
        if (iss_en && !(inst == 0 && iss_addr == 0)) mbusy[inst][iss_addr] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("a_rd1", rd1_a, m_rd(0, ra1));
    check("a_rd2", rd2_a, m_rd(0, ra2));
    check("a_rbusy1", rbusy1_a, m_rbusy(0, ra1));
    check("a_rbusy2", rbusy2_a, m_rbusy(0, ra2));
    check("a_busy_vec", busy_a, m_busy(0));
    check("b_rd1", rd1_b, m_rd(1, ra1));
    check("b_rd2", rd2_b, m_rd(1, ra2));
    check("b_rbusy1", rbusy1_b, m_rbusy(1, ra1));
    check("b_rbusy2", rbusy2_b, m_rbusy(1, ra2));
    check("b_busy_vec", busy_b, m_busy(1));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic idle;
    wea = 0; web = 0; waa = 0; wab = 0; wda = 0; wdb = 0; bea = 0; beb = 0;
    iss_en = 0; iss_addr = 0;
  endtask

  task automatic c_idle;
    c_wea = 0; c_web = 0; c_waa = 0; c_wab = 0; c_wda = 0; c_wdb = 0;
    c_bea = 0; c_beb = 0; c_iss_en = 0; c_iss_addr = 0; c_ra1 = 0; c_ra2 = 0;
  endtask

  initial begin
    reset = 1; ra1 = 0; ra2 = 0;
    idle();
    c_idle();
    tick();
    tick();
    reset = 0;
    ra1 = 5;
    settle();
    check("lit_reset_busy", busy_a, 32'h0);
    check("lit_reset_rd", rd1_a, 32'h0);

    // write-through bypass
    wea = 1; waa = 3; wda = 32'h12345678; bea = 4'hF; ra1 = 3;
    settle();
    check("lit_bypass_same_cycle", rd1_a, 32'h12345678);
    tick();
    idle();
    settle();
    check("lit_bypass_after_edge", rd1_a, 32'h12345678);

    // byte merge with B over A
    wea = 1; waa = 5; wda = 32'hAABBCCDD; bea = 4'hF;
    tick();
    wea = 1; waa = 5; wda = 32'h11111111; bea = 4'h3;
    web = 1; wab = 5; wdb = 32'h22222222; beb = 4'h6;
    tick();
    idle();
    ra2 = 5;
    settle();
    check("lit_merge_priority", rd2_a, 32'hAA222211);

    // scoreboard set / clear / re-issue with write
    iss_en = 1; iss_addr = 7;
    tick();
    idle();
    ra1 = 7;
    settle();
    check("lit_issue_busy", busy_a[7], 1'b1);
    check("lit_issue_rbusy", rbusy1_a, 1'b1);
    web = 1; wab = 7; wdb = 32'h00000055; beb = 4'hF;
    settle();
    check("lit_clear_rbusy_bypass", rbusy1_a, 1'b0);
    tick();
    idle();
    settle();
    check("lit_clear_busy", busy_a[7], 1'b0);
    iss_en = 1; iss_addr = 7; wea = 1; waa = 7; wda = 32'h00000077; bea = 4'hF;
    tick();
    idle();
    settle();
    check("lit_reissue_busy", busy_a[7], 1'b1);
    check("lit_reissue_data", rd1_a, 32'h00000077);
    wea = 1; waa = 7; wda = 32'hFFFFFFFF; bea = 4'h0;
    settle();
    check("lit_no_lane_rd", rd1_a, 32'h00000077);
    check("lit_no_lane_rbusy", rbusy1_a, 1'b1);
    tick();
    idle();

    // mixed traffic, including collisions between ports and issue
    for (int i = 0; i < 48; i++) begin
      wea = i[0]; waa = 5'(i * 7); wda = 32'(i) * 32'h9E3779B1; bea = 4'(i);
      web = (i % 3 == 0); wab = 5'(i * 5); wdb = ~wda; beb = 4'(i * 3);
      iss_en = (i % 4 == 1); iss_addr = 5'(i * 11);
      ra1 = waa; ra2 = 5'(i * 5);
      tick();
    end
    idle();

    // zero register
    wea = 1; waa = 0; wda = 32'hFFFFFFFF; bea = 4'hF; iss_en = 1; iss_addr = 0; ra1 = 0;
    settle();
    check("lit_zero_rd_same", rd1_a, 32'h0);
    check("lit_nozero_rd_same", rd1_b, 32'hFFFFFFFF);
    tick();
    idle();
    settle();
    check("lit_zero_rd", rd1_a, 32'h0);
    check("lit_zero_busy0", busy_a[0], 1'b0);
    check("lit_nozero_rd", rd1_b, 32'hFFFFFFFF);
    check("lit_nozero_busy0", busy_b[0], 1'b1);

    // reset in the middle of activity
    for (int i = 1; i < 32; i++) begin
      wea = 1; waa = 5'(i); wda = 32'(i) * 32'h01010101; bea = 4'hF;
      iss_en = 1; iss_addr = 5'(i);
      tick();
    end
    idle();
    settle();
    check("lit_all_busy_a", busy_a, 32'hFFFFFFFE);
    check("lit_all_busy_b", busy_b, 32'hFFFFFFFF);
    reset = 1; wea = 1; waa = 4; wda = 32'hCAFEF00D; bea = 4'hF; iss_en = 1; iss_addr = 4; ra1 = 4;
    settle();
    check("lit_reset_bypass", rd1_a, 32'hCAFEF00D);
    tick();
    reset = 0;
    idle();
    settle();
    check("lit_post_reset_busy_a", busy_a, 32'h0);
    check("lit_post_reset_busy_b", busy_b, 32'h0);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      #1;
      check("lit_post_reset_reg", {rd1_a, rd1_b}, 64'h0);
    end

    // 64-bit, 8-register configuration
    tick();
    c_wea = 1; c_waa = 2; c_wda = 64'h0123456789ABCDEF; c_bea = 8'hF0;
    tick();
    c_idle();
    c_ra1 = 2;
    settle();
    check("lit_w64_upper_lanes", c_rd1, 64'h0123456700000000);
    c_iss_en = 1; c_iss_addr = 3;
    tick();
    c_idle();
    c_ra1 = 3;
    settle();
    check("lit_w64_busy_vec", {56'h0, c_busy}, 64'h08);
    check("lit_w64_rbusy", c_rbusy1, 1'b1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
